reg_bank32: RTL and testbench
=============================

REG_BANK32 -- requirements
Module: reg_bank32

Interface
REQ-001 Parameter N: default 32; data width of every register.
REQ-002 Parameter ZERO_REG: default 1; when 1, register 0 reads as constant zero and ignores writes.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 wr_ena  input  1  write request, sampled on the rising edge of clk.
REQ-006 wr_addr  input  5  target register index, 0..31.
REQ-007 wr_data  input  N  value to write.
REQ-008 clr_dirty  input  1  clears all dirty flags.
REQ-009 q00..q31  output  N each  register contents; these are the 32 data inputs of the 32:1 read mux.
REQ-010 dirty  output  32  bit i set when register i has been written since the last reset or clear.
REQ-011 wr_count  output  8  count of accepted writes.
REQ-012 last_addr  output  5  index of the most recently accepted write.

Function
REQ-013 wr_addr SHALL be decoded 5-to-32 one-hot; at most one register is updated per cycle.
REQ-014 Accepted write: wr_ena=1 at a rising edge, and not (ZERO_REG=1 and wr_addr=0).
REQ-015 On an accepted write, register wr_addr SHALL load wr_data; all other registers hold.
REQ-016 Write latency SHALL be one edge; new data appears on qXX after the edge, with no combinational bypass from wr_data to any qXX.
REQ-017 With ZERO_REG=1, q00 SHALL be constant 0; a write to address 0 is dropped and changes neither dirty[0], wr_count nor last_addr.
REQ-018 With ZERO_REG=0, register 0 SHALL behave like every other register.
REQ-019 On an accepted write, dirty[wr_addr] SHALL be set.
REQ-020 When clr_dirty=1 at an edge, all dirty bits SHALL clear.
REQ-021 If clr_dirty and an accepted write occur at the same edge, all dirty bits clear except dirty[wr_addr], which ends set.
REQ-022 wr_count SHALL increment by 1 per accepted write.
REQ-023 wr_count SHALL wrap from 255 to 0, with no saturation and no flag.
REQ-024 clr_dirty SHALL not affect wr_count.
REQ-025 last_addr SHALL load wr_addr on each accepted write and otherwise hold.
REQ-026 Back-to-back writes to the same address on consecutive edges SHALL each take effect; the final value is the last write.
REQ-027 wr_ena=0 SHALL leave all state unchanged regardless of wr_addr, wr_data or X on those inputs.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force the following to 0: all registers, dirty, wr_count and last_addr.
REQ-029 While rst_n=0, writes and clr_dirty SHALL be ignored.
REQ-030 Deassertion is synchronized externally; the first accepted write is the first edge with rst_n=1.
REQ-031 Reset asserted mid-sequence SHALL discard any write presented at that edge.

Verification
REQ-032 Reset, then write 0xDEADBEEF to addr 5 -> q05=0xDEADBEEF next cycle; dirty=0x00000020; wr_count=1; last_addr=5; all other q=0.
REQ-033 ZERO_REG=1, write 0x1234 to addr 0 -> q00=0, dirty=0, wr_count=0, last_addr unchanged.
REQ-034 Write addr 3, then clr_dirty together with a write to addr 7 -> dirty=0x00000080; q03 retains its value; wr_count=2.
REQ-035 Issue 256 accepted writes -> wr_count returns to 0; issue 1 more -> wr_count=1.
REQ-036 Write all 31 nonzero addresses with value = address -> qXX=XX; dirty=0xFFFFFFFE; then hold wr_ena=0 with random addr and data -> no change.
REQ-037 Drop rst_n mid-cycle after several writes -> all outputs 0 before the next edge; a write presented at an edge during reset -> no effect.

Source files
------------

// File: rtl/reg_bank32_if.sv
// reg_bank32_if: write-side bus for reg_bank32
//   wr_ena    write request
//   wr_addr   target register index
//   wr_data   value to write
//   clr_dirty clear all dirty flags
interface reg_bank32_if #(parameter int N = 32);
  logic         wr_ena;
  logic [4:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic         clr_dirty;
  modport master (output wr_ena, wr_addr, wr_data, clr_dirty);
  modport slave  (input  wr_ena, wr_addr, wr_data, clr_dirty);
endinterface

// File: rtl/reg_bank32.sv
// reg_bank32: 32 x N register bank with dirty tracking, write counter and last-address capture
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             write bus (wr_ena, wr_addr, wr_data, clr_dirty)
//   q00..q31        register contents
//   dirty           per-register written-since-clear flags
//   wr_count        accepted-write count, wraps at 256
//   last_addr       index of most recent accepted write
module reg_bank32 #(
  parameter int N        = 32,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_bank32_if.slave    bus,
  output logic [N-1:0]   q00, q01, q02, q03, q04, q05, q06, q07,
  output logic [N-1:0]   q08, q09, q10, q11, q12, q13, q14, q15,
  output logic [N-1:0]   q16, q17, q18, q19, q20, q21, q22, q23,
  output logic [N-1:0]   q24, q25, q26, q27, q28, q29, q30, q31,
  output logic [31:0]    dirty,
  output logic [7:0]     wr_count,
  output logic [4:0]     last_addr
);
  logic [31:0][N-1:0] regs;
  logic               acc;
  logic [31:0]        sel;
  // a write to the hardwired zero register is dropped entirely, including bookkeeping
  assign acc = bus.wr_ena && !(ZERO_REG != 0 && bus.wr_addr == 5'd0);
  assign sel = acc ? 32'd1 << bus.wr_addr : 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs      <= '0;
      dirty     <= '0;
      wr_count  <= '0;
      last_addr <= '0;
    end else begin
      for (int k = 0; k < 32; k++)
        if (sel[k]) regs[k] <= bus.wr_data;
      // the write's own dirty bit survives a simultaneous clear
      dirty    <= (bus.clr_dirty ? 32'd0 : dirty) | sel;
      wr_count <= wr_count + {7'd0, acc};
      if (acc) last_addr <= bus.wr_addr;
    end
  assign q00 = ZERO_REG != 0 ? '0 : regs[0];
  assign {q31, q30, q29, q28, q27, q26, q25, q24, q23, q22, q21, q20, q19, q18, q17, q16,
          q15, q14, q13, q12, q11, q10, q09, q08, q07, q06, q05, q04, q03, q02, q01} = regs[31:1];
endmodule

// File: tb/tb_reg_bank32.sv
// tb_reg_bank32: randomized self-checking bench for reg_bank32 against a behavioural model
module tb_reg_bank32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] q [32];
  logic [31:0] dirty;
  logic [7:0]  wr_count;
  logic [4:0]  last_addr;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_q [32];
  logic [31:0] m_dirty;
  int          m_writes;
  logic [4:0]  m_last;

  always #5 clk = ~clk;

  reg_bank32_if #(.N(32)) bus ();

  reg_bank32 #(.N(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .q00(q[0]),  .q01(q[1]),  .q02(q[2]),  .q03(q[3]),  .q04(q[4]),  .q05(q[5]),  .q06(q[6]),  .q07(q[7]),
    .q08(q[8]),  .q09(q[9]),  .q10(q[10]), .q11(q[11]), .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
    .q16(q[16]), .q17(q[17]), .q18(q[18]), .q19(q[19]), .q20(q[20]), .q21(q[21]), .q22(q[22]), .q23(q[23]),
    .q24(q[24]), .q25(q[25]), .q26(q[26]), .q27(q[27]), .q28(q[28]), .q29(q[29]), .q30(q[30]), .q31(q[31]),
    .dirty(dirty), .wr_count(wr_count), .last_addr(last_addr)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_q[i] = 32'd0;
    m_dirty  = 32'd0;
    m_writes = 0;
    m_last   = 5'd0;
  endtask

  task automatic model_apply(input bit ena, input bit [4:0] a, input bit [31:0] d, input bit clr);
    if (clr) m_dirty = 32'd0;
    if (ena && a != 5'd0) begin
      m_q[a]     = d;
      m_dirty[a] = 1'b1;
      m_writes   = m_writes + 1;
      m_last     = a;
    end
  endtask

  // drives one edge's worth of inputs from a negedge and returns at the following negedge
  task automatic cyc(input bit ena, input bit [4:0] a, input bit [31:0] d, input bit clr);
    bus.wr_ena = ena; bus.wr_addr = a; bus.wr_data = d; bus.clr_dirty = clr;
    @(posedge clk);
    model_apply(ena, a, d, clr);
    @(negedge clk);
    bus.wr_ena = 1'b0; bus.clr_dirty = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 32; i++) if (q[i] !== 32'd0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL reset_q: %0d registers nonzero, required 0", bad); end
    tests++; if (dirty !== 32'd0) begin fails++; $display("FAIL reset_dirty: got %h want 0", dirty); end
    tests++; if (wr_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", wr_count); end
    tests++; if (last_addr !== 5'd0) begin fails++; $display("FAIL reset_last: got %0d want 0", last_addr); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_write();
    int bad;
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    tests++; if (q[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_q05: got %h want deadbeef", q[5]); end
    tests++; if (dirty !== 32'h00000020) begin fails++; $display("FAIL basic_dirty: got %h want 00000020", dirty); end
    tests++; if (wr_count !== 8'd1) begin fails++; $display("FAIL basic_count: got %0d want 1", wr_count); end
    tests++; if (last_addr !== 5'd5) begin fails++; $display("FAIL basic_last: got %0d want 5", last_addr); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (i != 5 && q[i] !== 32'd0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL basic_others: %0d other registers nonzero, required 0", bad); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    cyc(1'b1, 5'd0, 32'h1234, 1'b0);
    tests++; if (q[0] !== 32'd0) begin fails++; $display("FAIL zero_q00: got %h want 0", q[0]); end
    tests++; if (dirty !== 32'd0) begin fails++; $display("FAIL zero_dirty: got %h want 0", dirty); end
    tests++; if (wr_count !== 8'd0) begin fails++; $display("FAIL zero_count: got %0d want 0", wr_count); end
    tests++; if (last_addr !== 5'd0) begin fails++; $display("FAIL zero_last: got %0d want 0", last_addr); end
  endtask

  task automatic test_clr_with_write();
    logic [31:0] v3;
    do_reset();
    v3 = $urandom;
    cyc(1'b1, 5'd3, v3, 1'b0);
    cyc(1'b1, 5'd7, $urandom, 1'b1);
    tests++; if (dirty !== 32'h00000080) begin fails++; $display("FAIL clr_dirty: got %h want 00000080", dirty); end
    tests++; if (q[3] !== v3) begin fails++; $display("FAIL clr_q03: got %h want %h", q[3], v3); end
    tests++; if (wr_count !== 8'd2) begin fails++; $display("FAIL clr_count: got %0d want 2", wr_count); end
    tests++; if (q[7] !== m_q[7]) begin fails++; $display("FAIL clr_q07: got %h want %h", q[7], m_q[7]); end
    cyc(1'b0, 5'd0, 32'd0, 1'b1);
    tests++; if (dirty !== 32'd0 || wr_count !== 8'd2) begin fails++; $display("FAIL clr_only: dirty %h count %0d want 0 and 2", dirty, wr_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus.wr_ena = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = v; bus.clr_dirty = 1'b0;
      @(posedge clk);
      model_apply(1'b1, 5'd9, v, 1'b0);
      #1;
      tests++; if (q[9] !== v) begin fails++; $display("FAIL b2b_q09_%0d: got %h want %h", i, q[9], v); end
    end
    @(negedge clk);
    bus.wr_ena = 1'b0;
    tests++; if (wr_count !== 8'(m_writes % 256)) begin fails++; $display("FAIL b2b_count: got %0d want %0d", wr_count, m_writes % 256); end
  endtask

  task automatic test_wrap();
    logic [4:0] a;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = 5'($urandom_range(31, 1));
      cyc(1'b1, a, $urandom, 1'b0);
    end
    tests++; if (wr_count !== 8'd0) begin fails++; $display("FAIL wrap_256: got %0d want 0", wr_count); end
    tests++; if (last_addr !== m_last) begin fails++; $display("FAIL wrap_last: got %0d want %0d", last_addr, m_last); end
    cyc(1'b1, 5'd17, $urandom, 1'b0);
    tests++; if (wr_count !== 8'd1) begin fails++; $display("FAIL wrap_257: got %0d want 1", wr_count); end
  endtask

  task automatic test_fill_hold();
    int bad;
    do_reset();
    for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'(i), 1'b0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (q[i] !== 32'(i)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL fill_q: %0d registers differ from their index", bad); end
    tests++; if (dirty !== 32'hFFFFFFFE) begin fails++; $display("FAIL fill_dirty: got %h want fffffffe", dirty); end
    tests++; if (wr_count !== 8'd31) begin fails++; $display("FAIL fill_count: got %0d want 31", wr_count); end
    for (int i = 0; i < 20; i++) cyc(1'b0, 5'($urandom), $urandom, 1'b0);
    bus.wr_addr = 'x; bus.wr_data = 'x;
    @(posedge clk); @(negedge clk);
    bad = 0;
    for (int i = 0; i < 32; i++) if (q[i] !== 32'(i)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_q: %0d registers changed with wr_ena low", bad); end
    tests++; if (dirty !== 32'hFFFFFFFE || wr_count !== 8'd31 || last_addr !== 5'd31) begin
      fails++; $display("FAIL hold_state: dirty %h count %0d last %0d want fffffffe 31 31", dirty, wr_count, last_addr);
    end
  endtask

  task automatic test_random();
    bit ena, clr;
    int bad;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      ena = ($urandom_range(3) != 0);
      clr = ($urandom_range(7) == 0);
      cyc(ena, 5'($urandom), $urandom, clr);
      bad = 0;
      for (int i = 0; i < 32; i++) if (q[i] !== m_q[i]) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL rand_q_%0d: %0d registers differ from model", n, bad); end
      tests++; if (dirty !== m_dirty) begin fails++; $display("FAIL rand_dirty_%0d: got %h want %h", n, dirty, m_dirty); end
      tests++; if (wr_count !== 8'(m_writes % 256) || last_addr !== m_last) begin
        fails++; $display("FAIL rand_cnt_%0d: count %0d last %0d want %0d %0d", n, wr_count, last_addr, m_writes % 256, m_last);
      end
    end
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 5'($urandom_range(31, 1)), $urandom | 32'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 32; i++) if (q[i] !== 32'd0) bad++;
    tests++; if (bad != 0 || dirty !== 32'd0 || wr_count !== 8'd0 || last_addr !== 5'd0) begin
      fails++; $display("FAIL async_reset: %0d regs nonzero dirty %h count %0d last %0d want all 0", bad, dirty, wr_count, last_addr);
    end
    model_reset();
    @(negedge clk);
    bus.wr_ena = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hA5A5A5A5; bus.clr_dirty = 1'b1;
    @(posedge clk); #1;
    tests++; if (q[4] !== 32'd0 || dirty !== 32'd0 || wr_count !== 8'd0 || last_addr !== 5'd0) begin
      fails++; $display("FAIL reset_write: q04 %h dirty %h count %0d last %0d want all 0", q[4], dirty, wr_count, last_addr);
    end
    @(negedge clk);
    bus.wr_ena = 1'b0; bus.clr_dirty = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 5'd4, 32'h0BADF00D, 1'b0);
    tests++; if (q[4] !== 32'h0BADF00D || wr_count !== 8'd1) begin
      fails++; $display("FAIL post_reset_write: q04 %h count %0d want 0badf00d 1", q[4], wr_count);
    end
  endtask

  initial begin
    bus.wr_ena = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.clr_dirty = 1'b0;
    model_reset();
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_zero_reg();
    test_clr_with_write();
    test_wrap();
    test_fill_hold();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
